reset_seq: RTL and testbench
============================

# reset_seq

Parametrised reset sequencer, successor to the single-domain `reset_sync`. It sits behind the reset synchroniser, in the already-synchronised clock domain. It merges several synchronous reset-request sources and enforces a minimum reset hold (stretch). It then releases `NUM_OUT` downstream active-low resets one at a time, in index order, with a programmable stagger and an optional per-domain acknowledge handshake.

## Interface
Parameters:
- `NUM_REQ`, 2, number of reset-request inputs (≥1)
- `NUM_OUT`, 4, number of sequenced reset outputs (≥1)
- `STRETCH_CYCLES`, 16, minimum cycles all outputs stay asserted after the last request clears (≥1)
- `STAGGER_CYCLES`, 8, minimum cycles between successive output releases (≥1)

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `req_i`  in  NUM_REQ  reset requests, active-high, synchronous to `clk_i`, level-sensitive
- `ack_i`  in  NUM_OUT  domain-ready acknowledges, active-high, bit k belongs to `rstn_o[k]`
- `rstn_o`  out  NUM_OUT  sequenced resets, active-low, registered
- `done_o`  out  1  high when all outputs are released (state RUN), registered
- `cause_o`  out  NUM_REQ  sticky record of which requests caused the current or last sequence, registered

## Operation
- FSM states:
  - ASSERT: all `rstn_o`=0, counter cleared.
  - STRETCH: counter counts 0..STRETCH_CYCLES-1.
  - RELEASE(k): k = index of the most recently released output.
  - RUN.
- Transitions:
  - `rst_i`=1 has priority. Next state ASSERT, `rstn_o`=0, `done_o`=0, `cause_o`=0, k=0.
  - Any `req_i` bit high, in any state: next state ASSERT, all `rstn_o`=0, `done_o`=0.
  - ASSERT with `req_i`=0: next state STRETCH, counter=0.
  - STRETCH at counter=STRETCH_CYCLES-1: `rstn_o[0]`←1, next state RELEASE(0), counter=0.
  - RELEASE(k): counter increments, saturating at STAGGER_CYCLES-1. Advance when counter=STAGGER_CYCLES-1 and the ack condition holds (see Configuration).
    - k<NUM_OUT-1: `rstn_o[k+1]`←1, go to RELEASE(k+1), counter=0.
    - k=NUM_OUT-1: go to RUN, `done_o`←1.
- A released output stays released until the next ASSERT. Outputs are never released out of index order.
- `cause_o` behaviour:
  - On a request-triggered entry to ASSERT from STRETCH, RELEASE or RUN, `cause_o` loads `req_i`.
  - While in ASSERT, `cause_o` ORs in `req_i` every cycle.
  - Otherwise `cause_o` holds its value.
- Counter width is `$clog2(max(STRETCH_CYCLES,STAGGER_CYCLES)+1)`. The counter never wraps.

## Timing
- Reset values: `rstn_o`=0, `done_o`=0, `cause_o`=0, state ASSERT.
- All outputs are registered. There is no combinational path from input to output.
- Request to reset: with `req_i` sampled high at edge E, all `rstn_o` are 0 after edge E (1-cycle latency).
- Release latency:
  - Let edge 1 be the first edge sampling `rst_i`=0 and `req_i`=0.
  - `rstn_o[0]` rises after edge STRETCH_CYCLES+1.
  - With acks already high, `rstn_o[k]` rises exactly STAGGER_CYCLES edges after `rstn_o[k-1]`.
  - `done_o` rises STAGGER_CYCLES edges after `rstn_o[NUM_OUT-1]`.
- A request pulse of a single cycle is sufficient. The stretch restarts from 0 after every request.
- `req_i` and `rst_i` arriving on the same edge: `rst_i` wins and `cause_o` is 0.
- A request arriving mid-RELEASE drops every output, including already-released ones, on the next edge.

## Configuration
- `RESET_SEQ_ACK_EN` defined: RELEASE(k) additionally requires `ack_i[k]`=1 to advance.
  - A late ack extends the gap beyond STAGGER_CYCLES. The next release occurs on the edge after ack is sampled with the counter saturated.
  - A missing ack stalls the sequence indefinitely.
- Not defined: `ack_i` is ignored and the port remains present. The release spacing is exactly STAGGER_CYCLES.

## Structure
- Shared package `reset_seq_pkg` holds:
  - the state enum (ASSERT, STRETCH, RELEASE, RUN);
  - the `max`/counter-width helper function;
  - default parameter constants.
- One sub-module is natural: `reset_seq_timer`. It is a loadable up-counter with a clear input, a saturate-at-limit input and a `hit` output, shared by STRETCH and RELEASE.

## Test plan
1. Defaults. Set `rst_i`=1 for 3 cycles, then 0, with `req_i`=0 and `ack_i`=all 1. Expect `rstn_o[0]` rising after edge 17, then bits 1/2/3 at +8/+16/+24 edges, `done_o` at +32, and `cause_o`=0.
2. From RUN, pulse `req_i`=2'b10 for one cycle. Expect `rstn_o`=0 and `done_o`=0 on the next edge, `cause_o`=2'b10, and the full sequence replaying 17 edges after the pulse.
3. During RELEASE(1), raise `req_i[0]` for 5 cycles. Expect all outputs dropped within 1 cycle, the stretch counting only after `req_i` clears, and `cause_o`=2'b01.
4. With `RESET_SEQ_ACK_EN`, hold `ack_i[1]`=0 for 20 cycles after `rstn_o[1]` rises. Expect `rstn_o[2]` to stay 0 until the edge after `ack_i[1]` rises, then the normal spacing.
5. Drive `rst_i`=1 and `req_i`=2'b11 on the same edge. Expect state ASSERT, `cause_o`=0 and `rstn_o`=0.
6. Set `NUM_OUT`=1, `STRETCH_CYCLES`=1, `STAGGER_CYCLES`=1. Expect `rstn_o` high 2 edges after reset release and `done_o` 1 edge later.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state codes, default parameters
// and the counter-width helper.
package reset_seq_pkg;

    localparam int unsigned DEF_NUM_REQ        = 2;
    localparam int unsigned DEF_NUM_OUT        = 4;
    localparam int unsigned DEF_STRETCH_CYCLES = 16;
    localparam int unsigned DEF_STAGGER_CYCLES = 8;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_ASSERT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_STRETCH = 2'd1;
    localparam logic [STATE_W-1:0] ST_RELEASE = 2'd2;
    localparam logic [STATE_W-1:0] ST_RUN     = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold both the stretch and stagger terminal counts.
    function automatic int unsigned cnt_width(input int unsigned stretch, input int unsigned stagger);
        return $clog2(max_u(stretch, stagger) + 1);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Up-counter with synchronous clear that saturates at a run-time limit;
// hit flags that the count has reached the limit.
module reset_seq_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != limit)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign hit = (count_q == limit);

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: merges reset requests, stretches the hold, then releases the
// active-low outputs one by one in index order. Define RESET_SEQ_ACK_EN to
// gate each release step on the matching ack_i bit.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned NUM_OUT        = DEF_NUM_OUT,
    parameter int unsigned STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_OUT-1:0] ack_i,
    output logic [NUM_OUT-1:0] rstn_o,
    output logic               done_o,
    output logic [NUM_REQ-1:0] cause_o
);

    localparam int unsigned CW = cnt_width(STRETCH_CYCLES, STAGGER_CYCLES);
    localparam int unsigned KW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0]      STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0]      STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [KW-1:0]      K_LAST       = KW'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] FIRST_OUT    = NUM_OUT'(1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [NUM_OUT-1:0] rstn_q, rstn_d;
    logic               done_q, done_d;
    logic [NUM_REQ-1:0] cause_q, cause_d;

    logic               tmr_clr;
    logic               tmr_inc;
    logic [CW-1:0]      tmr_limit;
    logic               tmr_hit;
    logic               ack_ok_c;

`ifdef RESET_SEQ_ACK_EN
    assign ack_ok_c = |(ack_i & (FIRST_OUT << k_q));
`else
    logic unused_ack;
    assign unused_ack = ^ack_i;
    assign ack_ok_c   = 1'b1;
`endif

    reset_seq_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .limit (tmr_limit),
        .hit   (tmr_hit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ASSERT;
            k_q     <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and next-output logic; any request overrides the sequence.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rstn_d    = rstn_q;
        done_d    = done_q;
        cause_d   = cause_q;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        tmr_limit = STAGGER_LAST;

        if (|req_i) begin
            state_d = ST_ASSERT;
            k_d     = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
            tmr_clr = 1'b1;
            cause_d = (state_q == ST_ASSERT) ? (cause_q | req_i) : req_i;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_d = ST_STRETCH;
                    rstn_d  = '0;
                    done_d  = 1'b0;
                    tmr_clr = 1'b1;
                end
                ST_STRETCH: begin
                    tmr_limit = STRETCH_LAST;
                    if (tmr_hit) begin
                        state_d = ST_RELEASE;
                        k_d     = '0;
                        rstn_d  = FIRST_OUT;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    tmr_inc = 1'b1;
                    if (tmr_hit && ack_ok_c) begin
                        tmr_clr = 1'b1;
                        if (k_q == K_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            // Released bits are always a contiguous run from bit 0.
                            rstn_d = (rstn_q << 1) | FIRST_OUT;
                            k_d    = k_q + KW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    assign rstn_o  = rstn_q;
    assign done_o  = done_q;
    assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: default instance plus a minimal 1/1/1 instance,
// both compared every cycle against an edge-counting reference model.
module tb_reset_seq;

`ifdef RESET_SEQ_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] ack;
    logic [3:0] rstn;
    logic       done;
    logic [1:0] cause;
    logic [0:0] rstn_min;
    logic       done_min;
    logic [1:0] cause_min;

    always #5 clk = ~clk;

    reset_seq u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .ack_i   (ack),
        .rstn_o  (rstn),
        .done_o  (done),
        .cause_o (cause)
    );

    reset_seq #(
        .NUM_REQ        (2),
        .NUM_OUT        (1),
        .STRETCH_CYCLES (1),
        .STAGGER_CYCLES (1)
    ) u_min (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .ack_i   (ack[0:0]),
        .rstn_o  (rstn_min),
        .done_o  (done_min),
        .cause_o (cause_min)
    );

    // Model: quiet = edges since the last reset/request, released = outputs up,
    // since = edges since the last release.
    typedef struct {
        int         quiet;
        int         released;
        int         since;
        bit         done;
        logic [1:0] cause;
    } mdl_t;

    typedef struct packed {
        logic [3:0] rstn;
        logic       done;
        logic [1:0] cause;
    } exp_t;

    mdl_t m_main;
    mdl_t m_min;
    exp_t q_main[$];
    exp_t q_min[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic mdl_t mdl_step(input mdl_t m, input int n, input int s, input int t,
                                      input logic r, input logic [1:0] rq, input logic [3:0] a);
        mdl_t res;
        logic ack_bit;
        res = m;
        if (r) begin
            res.quiet = 0; res.released = 0; res.since = 0; res.done = 1'b0; res.cause = 2'b00;
        end else if (rq != 2'b00) begin
            res.cause    = (m.quiet == 0) ? (m.cause | rq) : rq;
            res.quiet    = 0; res.released = 0; res.since = 0; res.done = 1'b0;
        end else begin
            if (res.quiet < 1000000) res.quiet++;
            if (res.released == 0) begin
                if (res.quiet == s + 1) begin
                    res.released = 1;
                    res.since    = 0;
                end
            end else if (!res.done) begin
                res.since++;
                ack_bit = a[2'(res.released - 1)];
                if (res.since >= t && (!ACK_EN || ack_bit)) begin
                    if (res.released < n) begin
                        res.released++;
                        res.since = 0;
                    end else begin
                        res.done = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    function automatic exp_t mk_exp(input mdl_t m);
        exp_t e;
        e.rstn  = 4'((1 << m.released) - 1);
        e.done  = m.done;
        e.cause = m.cause;
        return e;
    endfunction

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // Stimulus: apply inputs at negedge, advance both models, queue expectations.
    task automatic drive(input logic r, input logic [1:0] rq, input logic [3:0] a);
        @(negedge clk);
        rst = r;
        req = rq;
        ack = a;
        m_main = mdl_step(m_main, 4, 16, 8, r, rq, a);
        m_min  = mdl_step(m_min, 1, 1, 1, r, rq, a);
        q_main.push_back(mk_exp(m_main));
        q_min.push_back(mk_exp(m_min));
        cyc++;
    endtask

    task automatic reach_released(input int target, input string nm);
        for (int i = 0; i < 200 && m_main.released != target; i++) drive(1'b0, 2'b00, 4'hF);
        n_checks++;
        if (m_main.released != target) begin
            n_fail++;
            $display("FAIL %s: model released %0d, wanted %0d", nm, m_main.released, target);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                check("rstn", rstn, e.rstn);
                check("done", 4'(done), 4'(e.done));
                check("cause", 4'(cause), 4'(e.cause));
            end
            if (q_min.size() > 0) begin
                e = q_min.pop_front();
                check("min_rstn", 4'(rstn_min), e.rstn);
                check("min_done", 4'(done_min), 4'(e.done));
                check("min_cause", 4'(cause_min), 4'(e.cause));
            end
        end
    end

    initial begin
        int         burst;
        logic [1:0] burst_req;
        logic [3:0] a;
        logic       r;
        logic [1:0] rq;

        m_main = '{quiet: 0, released: 0, since: 0, done: 1'b0, cause: 2'b00};
        m_min  = m_main;
        rst = 1'b1; req = 2'b00; ack = 4'hF;

        // Reset then full default sequence.
        repeat (3) drive(1'b1, 2'b00, 4'hF);
        repeat (60) drive(1'b0, 2'b00, 4'hF);

        // Single-cycle request from RUN.
        drive(1'b0, 2'b10, 4'hF);
        repeat (60) drive(1'b0, 2'b00, 4'hF);

        // Request held for 5 cycles during RELEASE(1).
        drive(1'b0, 2'b01, 4'hF);
        reach_released(2, "reach_release1");
        repeat (5) drive(1'b0, 2'b01, 4'hF);
        repeat (60) drive(1'b0, 2'b00, 4'hF);

        // Late ack on domain 1.
        drive(1'b0, 2'b10, 4'hF);
        reach_released(2, "reach_release1_ack");
        repeat (20) drive(1'b0, 2'b00, 4'b1101);
        repeat (60) drive(1'b0, 2'b00, 4'hF);

        // Reset and request together, then request alone while asserted.
        drive(1'b1, 2'b11, 4'hF);
        drive(1'b0, 2'b10, 4'hF);
        drive(1'b0, 2'b01, 4'hF);
        repeat (60) drive(1'b0, 2'b00, 4'hF);

        // Randomized traffic.
        burst = 0;
        burst_req = 2'b00;
        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(0, 399) == 0);
            if (burst == 0 && $urandom_range(0, 119) == 0) begin
                burst     = $urandom_range(1, 4);
                burst_req = 2'($urandom_range(1, 3));
            end
            if (burst > 0) begin
                rq = burst_req;
                burst--;
            end else begin
                rq = 2'b00;
            end
            a = 4'hF;
            if ($urandom_range(0, 5) == 0) a = a ^ 4'(1 << $urandom_range(0, 3));
            drive(r, rq, a);
        end
        repeat (20) drive(1'b0, 2'b00, 4'hF);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q_main.size() != 0 || q_min.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left, wanted 0", q_main.size(), q_min.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
